// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : spi_pkg                                                    |
// | Description : Shared SPI definitions: responder FSM state encoding,      |
// |               bus idle levels and common spi_rx/spi_tx constants.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package spi_pkg;

   // Responder transmitter states
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SHIFT      = 2'd1,
      ST_WAIT_DESEL = 2'd2
   } spi_state_e;

   // Bus idle levels: chip select is active-low, bus clock idles low
   localparam logic c_sel_idle      = 1'b1;
   localparam logic c_data_clk_idle = 1'b0;

   // Common spi_rx/spi_tx constants
   localparam int   c_spi_default_width = 16;
   localparam logic c_spi_tx_idle_data  = 1'b0;
   localparam logic c_spi_rx_msb_first  = 1'b1;

   // Bit-counter width able to hold the value w itself
   function automatic int spi_cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_resp_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : spi_resp_tx_if                                             |
// | Description : Word handshake and serial bus signals of spi_resp_tx.      |
// |   data_in        word for the next frame                                 |
// |   data_valid_in  data_in valid                                           |
// |   data_ready_out holding register empty                                  |
// |   data_clk_in    synchronized bus clock (idle low)                       |
// |   sel_in         synchronized chip select (active-low)                   |
// |   data_out       serial data, MSB first                                  |
// |   busy_out / done_out / abort_out / underrun_out  status                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface spi_resp_tx_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_valid_in;
   logic                  data_ready_out;
   logic                  data_clk_in;
   logic                  sel_in;
   logic                  data_out;
   logic                  busy_out;
   logic                  done_out;
   logic                  abort_out;
   logic                  underrun_out;

   // Responder side (the DUT)
   modport slave (
      input  data_in, data_valid_in, data_clk_in, sel_in,
      output data_ready_out, data_out, busy_out, done_out, abort_out, underrun_out
   );

   // Word source / bus controller side
   modport master (
      output data_in, data_valid_in, data_clk_in, sel_in,
      input  data_ready_out, data_out, busy_out, done_out, abort_out, underrun_out
   );
endinterface : spi_resp_tx_if
`default_nettype wire

// File: rtl/spi_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_edge_det                                               |
// | Description : Registers one already-synchronized signal and flags rising |
// |               and falling edges in the cycle where the live value        |
// |               differs from the registered copy.                          |
// |   clk_in, rst_in  clock, asynchronous active-high reset                  |
// |   sig_i           signal to watch                                        |
// |   rise_o, fall_o  combinational edge flags                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module spi_edge_det #(
   parameter logic RESET_VAL = 1'b0
) (
   input  wire logic clk_in,
   input  wire logic rst_in,
   input  wire logic sig_i,
   output      logic rise_o,
   output      logic fall_o
);
   logic sig_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sig_q <= RESET_VAL;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o =  sig_i & ~sig_q;
   assign fall_o = ~sig_i &  sig_q;
endmodule : spi_edge_det
`default_nettype wire

// File: rtl/spi_resp_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_resp_tx                                                |
// | Description : SPI responder transmitter. A one-word holding register     |
// |               feeds a shifter that is loaded on the chip-select falling  |
// |               edge and sent MSB first; the controller samples on bus     |
// |               clock rising edges, the shifter advances on falling edges. |
// |   clk_in  system clock        rst_in  asynchronous active-high reset     |
// |   bus     spi_resp_tx_if.slave (handshake, serial bus and status)        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module spi_resp_tx
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input wire logic     clk_in,
   input wire logic     rst_in,
   spi_resp_tx_if.slave bus
);
   localparam int CNT_W = spi_cnt_width(DATA_WIDTH);
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t c_last_cnt = cnt_t'(DATA_WIDTH - 1);
   localparam cnt_t c_one      = cnt_t'(1);

   spi_state_e            state_q;
   cnt_t                  cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  hold_full_q;
   logic                  armed_q;
   logic                  done_q;
   logic                  abort_q;
   logic                  underrun_q;

   logic sel_rise, sel_fall;
   logic dclk_rise, dclk_fall;
   logic accept_d;

   spi_edge_det #(.RESET_VAL(c_sel_idle)) u_sel_edge (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .sig_i  (bus.sel_in),
      .rise_o (sel_rise),
      .fall_o (sel_fall)
   );

   spi_edge_det #(.RESET_VAL(c_data_clk_idle)) u_dclk_edge (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .sig_i  (bus.data_clk_in),
      .rise_o (dclk_rise),
      .fall_o (dclk_fall)
   );

   // A word is taken only while the holding register is empty
   assign accept_d = bus.data_valid_in & ~hold_full_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         armed_q     <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
         underrun_q <= 1'b0;

         // sel_in must be seen high after reset before a falling edge can
         // start a frame; a select held low through reset is not a new frame.
         armed_q <= armed_q | bus.sel_in;

         if (accept_d) begin
            hold_q      <= bus.data_in;
            hold_full_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (sel_fall && armed_q) begin
                  state_q     <= ST_SHIFT;
                  cnt_q       <= '0;
                  shift_q     <= hold_full_q ? hold_q : '0;
                  underrun_q  <= ~hold_full_q;
                  // Accept can only coincide with an empty register, so the
                  // register ends up full exactly when a word arrives now.
                  hold_full_q <= accept_d;
               end
            end

            ST_SHIFT: begin
               if (sel_rise) begin
                  // The counter never sits at DATA_WIDTH in this state, so any
                  // deselect here is premature.
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  shift_q <= '0;
                  abort_q <= 1'b1;
               end else if (dclk_rise) begin
                  cnt_q <= cnt_q + c_one;
                  if (cnt_q == c_last_cnt) begin
                     // Last bit has just been sampled by the controller
                     state_q <= ST_WAIT_DESEL;
                     shift_q <= '0;
                     done_q  <= 1'b1;
                  end
               end else if (dclk_fall && (cnt_q >= c_one) && (cnt_q <= c_last_cnt)) begin
                  shift_q <= shift_q << 1;
               end
            end

            ST_WAIT_DESEL: begin
               if (bus.sel_in) begin
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // The shifter is cleared whenever the FSM leaves SHIFT, so its MSB is 0
   // in IDLE and WAIT_DESEL.
   assign bus.data_out       = shift_q[DATA_WIDTH-1];
   assign bus.data_ready_out = ~hold_full_q;
   assign bus.busy_out       = (state_q != ST_IDLE);
   assign bus.done_out       = done_q;
   assign bus.abort_out      = abort_q;
   assign bus.underrun_out   = underrun_q;
endmodule : spi_resp_tx
`default_nettype wire

// File: doc/spi_resp_tx.md
SPI_RESP_TX -- requirements
Module: spi_resp_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the number of bits per frame.
REQ-002 clk_in  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 data_in  input  DATA_WIDTH  word to transmit in the next frame.
REQ-005 data_valid_in  input  1  data_in is valid this cycle.
REQ-006 data_ready_out  output  1  the holding register is empty and can accept a word.
REQ-007 data_clk_in  input  1  bus clock from the controller, already synchronized to clk_in; idle low.
REQ-008 sel_in  input  1  chip select from the controller, already synchronized; active-low.
REQ-009 data_out  output  1  serial data to the controller, MSB first.
REQ-010 busy_out  output  1  a frame is in progress.
REQ-011 done_out  output  1  one-cycle pulse when a full frame has been shifted out.
REQ-012 abort_out  output  1  one-cycle pulse when sel_in deasserts before the frame is complete.
REQ-013 underrun_out  output  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-014 Edge detection SHALL use registered copies of sel_in and data_clk_in; an edge counts in the cycle where the current value differs from the registered copy.
REQ-015 Holding register handshake: a word SHALL be accepted on any cycle with data_valid_in and data_ready_out both high; data_ready_out SHALL go low on the next cycle.
REQ-016 States SHALL be IDLE, SHIFT and WAIT_DESEL.
REQ-017 IDLE -> SHIFT on a sel_in falling edge:
  - the shifter loads the holding word, or all-zeros if the register is empty;
  - if the register was empty, underrun_out pulses;
  - the holding register empties;
  - data_out shows the MSB from the next cycle.
REQ-018 In SHIFT, each data_clk_in rising edge SHALL increment the bit counter, which is $clog2(DATA_WIDTH+1) bits wide and cleared on frame start.
REQ-019 In SHIFT, each data_clk_in falling edge SHALL shift left by one while the counter is between 1 and DATA_WIDTH-1, so the controller samples a stable bit on every rising edge.
REQ-020 When the counter reaches DATA_WIDTH, the block SHALL pulse done_out in that same cycle and move to WAIT_DESEL.
REQ-021 WAIT_DESEL -> IDLE when sel_in is high; data_out SHALL hold 0 in WAIT_DESEL and in IDLE.
REQ-022 Abort: a sel_in rising edge in SHIFT with counter < DATA_WIDTH SHALL pulse abort_out, discard the shifter contents, go to IDLE and leave the holding register unchanged.
REQ-023 Simultaneous accept and frame start: the frame SHALL use the previous holding content (zeros plus underrun if empty), and the newly accepted word SHALL stay held for the next frame.
REQ-024 busy_out SHALL be high exactly in SHIFT and WAIT_DESEL.
REQ-025 Data clock edges seen in IDLE SHALL be ignored.
REQ-026 data_in SHALL be ignored in the same cycle when data_ready_out is low.

Reset
REQ-027 Asserting rst_in SHALL immediately, at any time including mid-frame, force:
  - state IDLE; counter 0; shifter 0; holding register empty;
  - data_ready_out 1; data_out, busy_out, done_out, abort_out, underrun_out 0;
  - edge-detect registers: sel 1, data_clk 0.
REQ-028 After rst_in is released, the first frame SHALL need a fresh sel_in falling edge.

Structure
REQ-029 The state enum (IDLE, SHIFT, WAIT_DESEL) SHALL be defined in shared package spi_pkg, alongside the spi_rx/spi_tx constants.
REQ-030 Edge detection SHALL be a single sub-module, spi_edge_det (registered input, rise and fall outputs), instantiated once for sel_in and once for data_clk_in.

Verification
REQ-031 Test: load 16'hBEE1, then drive a controller frame (DATA_PERIOD 20) through synchronizers into spi_rx. Required: rx_out = 16'hBEE1, one done_out pulse, no underrun_out.
REQ-032 Test: start a frame with no word loaded. Required: underrun_out pulses once and the receiver captures 16'h0000.
REQ-033 Test: load 16'hFEED, then raise sel_in after 7 bus clock rising edges. Required: abort_out pulses, no done_out, and busy_out is low on the following cycle.
REQ-034 Test: assert data_valid_in with 16'h1234 in the same cycle as the sel_in falling edge, with the register holding 16'hBEE1. Required: frame 1 = 16'hBEE1, frame 2 = 16'h1234.
REQ-035 Test: assert rst_in after 5 bits of a frame. Required: all outputs at reset values in the same cycle, and the next frame carrying 16'hFEED is received intact.
REQ-036 Test: two back-to-back frames. Required: data_ready_out is high again in the cycle after each frame start.
